// File: rtl/dff_reset_enable.sv
// dff_reset_enable
//   Clock-enabled D register with synchronous active-low reset. The default
//   form is a single 1-bit flop. Raising DEPTH turns it into an enable-gated
//   delay line in which all stages advance together.
//
// Parameters
//   WIDTH       : data width of d and q (>= 1)
//   DEPTH       : number of cascaded stages between d and q (>= 1)
//   RESET_VALUE : value loaded into every stage while rst_n is low
//
// Ports
//   clk    in   rising-edge clock, the only clock
//   rst_n  in   synchronous reset, active low; takes priority over enable
//   enable in   when high, the stages advance on the clock edge
//   d      in   [WIDTH-1:0] data into stage 0
//   q      out  [WIDTH-1:0] last stage, driven straight from a flop

module dff_reset_enable #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Reset is tested first so that X/Z on enable or d while rst_n is low
  // cannot reach the stages. Enable acts as a data-path hold mux, not a
  // clock gate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else if (enable) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: tb/tb_dff_reset_enable.sv
module tb_dff_reset_enable;

  logic       clk;
  logic       rn1, en1, d1;
  logic       q1;
  logic       rn8, en8;
  logic [7:0] d8;
  logic [7:0] q8;

  int vectors;
  int miscompares;

  dff_reset_enable u_bit (
    .clk    (clk),
    .rst_n  (rn1),
    .enable (en1),
    .d      (d1),
    .q      (q1)
  );

  dff_reset_enable #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE (8'hA5)
  ) u_byte (
    .clk    (clk),
    .rst_n  (rn8),
    .enable (en8),
    .d      (d8),
    .q      (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then return on the falling edge so that outputs are
  // sampled and inputs are driven while clk is low.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    rn1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
    rn8 = 1'b0; en8 = 1'b1; d8 = 8'hFF;
    step();
    chk("reset_bit", {7'd0, q1}, 8'h00);
    chk("reset_byte", q8, 8'hA5);

    for (int i = 0; i < 3; i++) begin
      d1 = ~d1;
      step();
      chk("reset_hold_bit", {7'd0, q1}, 8'h00);
    end

    // Load, one-edge latency
    rn1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
    step();
    chk("load_1", {7'd0, q1}, 8'h01);
    d1 = 1'b0;
    step();
    chk("load_0", {7'd0, q1}, 8'h00);

    // Hold
    d1 = 1'b1;
    step();
    chk("hold_setup", {7'd0, q1}, 8'h01);
    en1 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold", {7'd0, q1}, 8'h01);
    end
    en1 = 1'b1;
    step();
    chk("hold_release", {7'd0, q1}, 8'h00);

    // Synchronous reset asserted and released between edges
    d1 = 1'b1;
    step();
    chk("sync_setup", {7'd0, q1}, 8'h01);
    rn1 = 1'b0;
    #2;
    chk("sync_assert_midcycle", {7'd0, q1}, 8'h01);
    step();
    chk("sync_assert_edge", {7'd0, q1}, 8'h00);
    rn1 = 1'b1; en1 = 1'b0; d1 = 1'b1;
    #2;
    chk("sync_release_midcycle", {7'd0, q1}, 8'h00);
    step();
    chk("sync_release_disabled", {7'd0, q1}, 8'h00);
    en1 = 1'b1;
    step();
    chk("sync_release_enabled", {7'd0, q1}, 8'h01);

    // Reset beats enable
    rn1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
    step();
    chk("priority_reset", {7'd0, q1}, 8'h00);
    rn1 = 1'b1;
    step();
    chk("priority_after", {7'd0, q1}, 8'h01);

    // Unknown enable/d are masked while in reset
    rn1 = 1'b0; en1 = 1'bx; d1 = 1'bx;
    step();
    chk("reset_masks_x", {7'd0, q1}, 8'h00);

    // 8-bit, 3-stage delay line
    rn8 = 1'b1; en8 = 1'b1;
    d8 = 8'h01; step(); chk("pipe_e1", q8, 8'hA5);
    d8 = 8'h02; step(); chk("pipe_e2", q8, 8'hA5);
    d8 = 8'h03; step(); chk("pipe_e3", q8, 8'h01);
    en8 = 1'b0; d8 = 8'hFF;
    step();
    chk("pipe_disabled", q8, 8'h01);
    en8 = 1'b1; d8 = 8'h04;
    step();
    chk("pipe_e4", q8, 8'h02);

    rn8 = 1'b0; d8 = 8'h05;
    step();
    chk("pipe_reset", q8, 8'hA5);
    rn8 = 1'b1;
    d8 = 8'h06; step(); chk("pipe_refill1", q8, 8'hA5);
    d8 = 8'h07; step(); chk("pipe_refill2", q8, 8'hA5);
    d8 = 8'h08; step(); chk("pipe_refill3", q8, 8'h06);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
